// File: rtl/mc_control_sequencer.sv
// Multi-cycle control sequencer for the 32-bit MIPS process unit, with IN/OUT/HLT handshakes.
// Optional retired-instruction counter enabled by defining MC_SEQ_INSTR_COUNT_EN.
module mc_control_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [5:0]  ALU_ADD = 6'h20,
    parameter logic [5:0]  ALU_SUB = 6'h22
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Run,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic        InValid,
    output logic        InAck,
    output logic [5:0]  AluOP,
    output logic        RegDst,
    output logic        Branch,
    output logic        JumpReg,
    output logic        Jump,
    output logic        Jal,
    output logic        And,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        MemWrite,
    output logic        Immediate,
    output logic        RegWrite,
    output logic        Print,
    output logic        InSel,
    output logic        PcEn,
    output logic        Halted,
    output logic        IllegalOp,
    output logic [31:0] InstrCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_IN    = 6'h3C;
    localparam logic [5:0] OP_OUT   = 6'h3D;
    localparam logic [5:0] OP_HLT   = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [3:0] MEM_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_WAIT_IN, S_HALT
    } state_e;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       jump_reg;
        logic       jump;
        logic       jal;
        logic       and_op;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       immediate;
        logic       reg_write;
        logic       print;
        logic       in_sel;
        logic       in_ack;
        logic       pc_en;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    ctrl_t      ctrl_q, ctrl_d;

    // Controls for the EXEC cycle; evaluated in DECODE while OpCode/Funct are still live.
    function automatic ctrl_t exec_ctrl(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_JR) begin
                    c.jump_reg = 1'b1;
                    c.pc_en    = 1'b1;
                end else begin
                    c.alu_op  = fn;
                    c.reg_dst = 1'b1;
                end
            end
            OP_ADDI, OP_LW, OP_SW: begin
                c.immediate = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.alu_op = ALU_SUB;
                c.branch = 1'b1;
                c.and_op = 1'b1;
                c.pc_en  = 1'b1;
            end
            OP_J: begin
                c.jump  = 1'b1;
                c.pc_en = 1'b1;
            end
            OP_JAL: begin
                c.jump      = 1'b1;
                c.jal       = 1'b1;
                c.reg_write = 1'b1;
                c.pc_en     = 1'b1;
            end
            OP_OUT: begin
                c.print = 1'b1;
                c.pc_en = 1'b1;
            end
            default: begin
                c.pc_en      = 1'b1;
                c.illegal_op = 1'b1;
            end
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ctrl_d  = '0;
        case (state_q)
            S_FETCH: begin
                if (Run) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = OpCode;
                if (OpCode == OP_IN) begin
                    state_d = S_WAIT_IN;
                    if (InValid) begin
                        ctrl_d.in_ack    = 1'b1;
                        ctrl_d.in_sel    = 1'b1;
                        ctrl_d.reg_write = 1'b1;
                        ctrl_d.pc_en     = 1'b1;
                    end
                end else if (OpCode == OP_HLT) begin
                    state_d       = S_HALT;
                    ctrl_d.halted = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    ctrl_d  = exec_ctrl(OpCode, Funct);
                end
            end
            S_EXEC: begin
                if (ctrl_q.pc_en) begin
                    state_d = S_FETCH;
                end else if (op_q == OP_LW || op_q == OP_SW) begin
                    state_d          = S_MEM;
                    cnt_d            = MEM_LOAD;
                    ctrl_d.immediate = 1'b1;
                    ctrl_d.alu_op    = ALU_ADD;
                    if (op_q == OP_LW) begin
                        ctrl_d.mem_read = 1'b1;
                    end else if (MEM_LOAD == 4'd0) begin
                        ctrl_d.mem_write = 1'b1;
                        ctrl_d.pc_en     = 1'b1;
                    end
                end else if (op_q == OP_ADDI) begin
                    state_d          = S_WB;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.immediate = 1'b1;
                    ctrl_d.pc_en     = 1'b1;
                end else begin
                    state_d          = S_WB;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.reg_dst   = 1'b1;
                    ctrl_d.pc_en     = 1'b1;
                end
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    if (op_q == OP_LW) begin
                        state_d           = S_WB;
                        ctrl_d.immediate  = 1'b1;
                        ctrl_d.alu_op     = ALU_ADD;
                        ctrl_d.mem_to_reg = 1'b1;
                        ctrl_d.reg_write  = 1'b1;
                        ctrl_d.pc_en      = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    // Still counting down: the SW write lands in the cycle whose count reaches 0.
                    cnt_d            = cnt_q - 4'd1;
                    ctrl_d.immediate = 1'b1;
                    ctrl_d.alu_op    = ALU_ADD;
                    if (op_q == OP_LW) begin
                        ctrl_d.mem_read = 1'b1;
                    end else if (cnt_q == 4'd1) begin
                        ctrl_d.mem_write = 1'b1;
                        ctrl_d.pc_en     = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_WAIT_IN: begin
                if (ctrl_q.in_ack) begin
                    state_d = S_FETCH;
                end else if (InValid) begin
                    ctrl_d.in_ack    = 1'b1;
                    ctrl_d.in_sel    = 1'b1;
                    ctrl_d.reg_write = 1'b1;
                    ctrl_d.pc_en     = 1'b1;
                end
            end
            S_HALT: begin
                ctrl_d.halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign AluOP     = ctrl_q.alu_op;
    assign RegDst    = ctrl_q.reg_dst;
    assign Branch    = ctrl_q.branch;
    assign JumpReg   = ctrl_q.jump_reg;
    assign Jump      = ctrl_q.jump;
    assign Jal       = ctrl_q.jal;
    assign And       = ctrl_q.and_op;
    assign MemRead   = ctrl_q.mem_read;
    assign MemToReg  = ctrl_q.mem_to_reg;
    assign MemWrite  = ctrl_q.mem_write;
    assign Immediate = ctrl_q.immediate;
    assign RegWrite  = ctrl_q.reg_write;
    assign Print     = ctrl_q.print;
    assign InSel     = ctrl_q.in_sel;
    assign InAck     = ctrl_q.in_ack;
    assign PcEn      = ctrl_q.pc_en;
    assign Halted    = ctrl_q.halted;
    assign IllegalOp = ctrl_q.illegal_op;

`ifdef MC_SEQ_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            count_q <= '0;
        end else if (ctrl_q.pc_en) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign InstrCount = count_q;
`else
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_mc_control_sequencer.sv
// Directed bench for mc_control_sequencer (MEM_LAT=3); per-cycle control traces vs hand-built tables.
module tb_mc_control_sequencer;

    localparam int MEM_LAT = 3;

    logic        Clk, ResetN, Run, InValid;
    logic [5:0]  OpCode, Funct;
    logic        InAck, RegDst, Branch, JumpReg, Jump, Jal, And_o, MemRead, MemToReg;
    logic        MemWrite, Immediate, RegWrite, Print, InSel, PcEn, Halted, IllegalOp;
    logic [5:0]  AluOP;
    logic [31:0] InstrCount;

    mc_control_sequencer #(.MEM_LAT(MEM_LAT)) dut (
        .Clk(Clk), .ResetN(ResetN), .Run(Run), .OpCode(OpCode), .Funct(Funct),
        .InValid(InValid), .InAck(InAck), .AluOP(AluOP), .RegDst(RegDst),
        .Branch(Branch), .JumpReg(JumpReg), .Jump(Jump), .Jal(Jal), .And(And_o),
        .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
        .Immediate(Immediate), .RegWrite(RegWrite), .Print(Print), .InSel(InSel),
        .PcEn(PcEn), .Halted(Halted), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
    );

    logic [22:0] obs;
    assign obs = {AluOP, RegDst, Branch, JumpReg, Jump, Jal, And_o, MemRead, MemToReg,
                  MemWrite, Immediate, RegWrite, Print, InSel, InAck, PcEn, Halted, IllegalOp};

    localparam logic [22:0] M_IOP  = 23'd1 << 0;
    localparam logic [22:0] M_HALT = 23'd1 << 1;
    localparam logic [22:0] M_PC   = 23'd1 << 2;
    localparam logic [22:0] M_ACK  = 23'd1 << 3;
    localparam logic [22:0] M_ISEL = 23'd1 << 4;
    localparam logic [22:0] M_PRT  = 23'd1 << 5;
    localparam logic [22:0] M_RW   = 23'd1 << 6;
    localparam logic [22:0] M_IMM  = 23'd1 << 7;
    localparam logic [22:0] M_MW   = 23'd1 << 8;
    localparam logic [22:0] M_MTR  = 23'd1 << 9;
    localparam logic [22:0] M_MR   = 23'd1 << 10;
    localparam logic [22:0] M_AND  = 23'd1 << 11;
    localparam logic [22:0] M_JAL  = 23'd1 << 12;
    localparam logic [22:0] M_JMP  = 23'd1 << 13;
    localparam logic [22:0] M_JR   = 23'd1 << 14;
    localparam logic [22:0] M_BR   = 23'd1 << 15;
    localparam logic [22:0] M_RD   = 23'd1 << 16;
    localparam logic [22:0] A_ADD  = {6'h20, 17'd0};
    localparam logic [22:0] A_SUB  = {6'h22, 17'd0};

`ifdef MC_SEQ_INSTR_COUNT_EN
    localparam logic [31:0] EXP_COUNT = 32'd4;
`else
    localparam logic [31:0] EXP_COUNT = 32'd0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [22:0] trace [1:32];
    logic [22:0] ev    [1:32];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Called at a negedge with the FSM in FETCH; that cycle is cycle 1.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input int ncyc, input int inv_at);
        Run = 1'b1; OpCode = op; Funct = fn;
        trace[1] = obs;
        for (int k = 2; k <= ncyc; k++) begin
            @(negedge Clk);
            trace[k] = obs;
            if (k == 2) Run = 1'b0;
            if (k == 3) begin OpCode = 6'h3F; Funct = 6'h08; end
            if (k == inv_at) InValid = 1'b1;
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Run = 1'b0; InValid = 1'b0; OpCode = 6'h00; Funct = 6'h00;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL reset_outputs got %h want 0", obs); end
        n_cmp++;
        if (InstrCount !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", InstrCount); end
        ResetN = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL reset_fetch got %h want 0", obs); end
    endtask

    task automatic test_rtype();
        logic [5:0] ops [3];
        logic [5:0] fns [3];
        ops = '{6'h00, 6'h00, 6'h08};
        fns = '{6'h20, 6'h08, 6'h00};
        for (int t = 0; t < 3; t++) begin
            for (int k = 1; k <= 32; k++) ev[k] = '0;
            case (t)
                0: begin ev[3] = A_ADD | M_RD; ev[4] = M_RW | M_RD | M_PC; end
                1: ev[3] = M_JR | M_PC;
                default: begin ev[3] = A_ADD | M_IMM; ev[4] = M_RW | M_IMM | M_PC; end
            endcase
            issue(ops[t], fns[t], 6, 0);
            for (int k = 1; k <= 6; k++) begin
                n_cmp++;
                if (trace[k] !== ev[k]) begin
                    n_err++;
                    $display("FAIL rtype[%0d] cycle %0d got %h want %h", t, k, trace[k], ev[k]);
                end
            end
        end
    endtask

    task automatic test_mem();
        for (int t = 0; t < 2; t++) begin
            for (int k = 1; k <= 32; k++) ev[k] = '0;
            ev[3] = A_ADD | M_IMM;
            if (t == 0) begin
                ev[4] = A_ADD | M_IMM | M_MR; ev[5] = ev[4]; ev[6] = ev[4];
                ev[7] = A_ADD | M_IMM | M_MTR | M_RW | M_PC;
                issue(6'h23, 6'h00, 9, 0);
            end else begin
                ev[4] = A_ADD | M_IMM; ev[5] = ev[4];
                ev[6] = A_ADD | M_IMM | M_MW | M_PC;
                issue(6'h2B, 6'h00, 9, 0);
            end
            for (int k = 1; k <= 9; k++) begin
                n_cmp++;
                if (trace[k] !== ev[k]) begin
                    n_err++;
                    $display("FAIL mem[%0d] cycle %0d got %h want %h", t, k, trace[k], ev[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_lw();
        Run = 1'b1; OpCode = 6'h23; Funct = 6'h00;
        @(negedge Clk); Run = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (obs !== (A_ADD | M_IMM | M_MR)) begin
            n_err++; $display("FAIL midlw_mem got %h want %h", obs, A_ADD | M_IMM | M_MR);
        end
        #2 ResetN = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 23'd0) begin n_err++; $display("FAIL midlw_async got %h want 0", obs); end
        n_cmp++;
        if (InstrCount !== 32'd0) begin n_err++; $display("FAIL midlw_count got %0d want 0", InstrCount); end
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (obs !== 23'd0) begin n_err++; $display("FAIL midlw_hold%0d got %h want 0", k, obs); end
        end
        ResetN = 1'b1;
        for (int k = 1; k <= 32; k++) ev[k] = '0;
        ev[3] = M_JMP | M_PC;
        issue(6'h02, 6'h00, 5, 0);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (trace[k] !== ev[k]) begin
                n_err++; $display("FAIL midlw_after cycle %0d got %h want %h", k, trace[k], ev[k]);
            end
        end
    endtask

    task automatic test_in();
        for (int t = 0; t < 2; t++) begin
            for (int k = 1; k <= 32; k++) ev[k] = '0;
            if (t == 0) begin
                ev[13] = M_ACK | M_ISEL | M_RW | M_PC;
                issue(6'h3C, 6'h00, 17, 12);
            end else begin
                ev[3] = M_ACK | M_ISEL | M_RW | M_PC;
                issue(6'h3C, 6'h00, 6, 0);
            end
            for (int k = 1; k <= (t == 0 ? 17 : 6); k++) begin
                n_cmp++;
                if (trace[k] !== ev[k]) begin
                    n_err++;
                    $display("FAIL in[%0d] cycle %0d got %h want %h", t, k, trace[k], ev[k]);
                end
            end
        end
        InValid = 1'b0;
    endtask

    task automatic test_run_gate();
        OpCode = 6'h02; Funct = 6'h00; Run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (obs !== 23'd0) begin n_err++; $display("FAIL rungate_hold%0d got %h want 0", k, obs); end
        end
        for (int k = 1; k <= 32; k++) ev[k] = '0;
        ev[3] = M_JMP | M_PC;
        issue(6'h02, 6'h00, 5, 0);
        for (int k = 1; k <= 5; k++) begin
            n_cmp++;
            if (trace[k] !== ev[k]) begin
                n_err++; $display("FAIL rungate_run cycle %0d got %h want %h", k, trace[k], ev[k]);
            end
        end
    endtask

    task automatic test_program();
        logic [5:0]  ops [4];
        logic [22:0] ex3 [4];
        ops = '{6'h04, 6'h03, 6'h3D, 6'h11};
        ex3 = '{A_SUB | M_BR | M_AND | M_PC, M_JMP | M_JAL | M_RW | M_PC, M_PRT | M_PC, M_IOP | M_PC};
        ResetN = 1'b0;
        @(negedge Clk);
        ResetN = 1'b1;
        @(negedge Clk);
        for (int t = 0; t < 4; t++) begin
            for (int k = 1; k <= 32; k++) ev[k] = '0;
            ev[3] = ex3[t];
            issue(ops[t], 6'h00, 5, 0);
            for (int k = 1; k <= 5; k++) begin
                n_cmp++;
                if (trace[k] !== ev[k]) begin
                    n_err++;
                    $display("FAIL prog[%0d] cycle %0d got %h want %h", t, k, trace[k], ev[k]);
                end
            end
        end
        for (int k = 1; k <= 32; k++) ev[k] = (k >= 3) ? M_HALT : 23'd0;
        issue(6'h3F, 6'h00, 6, 0);
        for (int k = 1; k <= 6; k++) begin
            n_cmp++;
            if (trace[k] !== ev[k]) begin
                n_err++; $display("FAIL prog_hlt cycle %0d got %h want %h", k, trace[k], ev[k]);
            end
        end
        n_cmp++;
        if (InstrCount !== EXP_COUNT) begin
            n_err++; $display("FAIL prog_count got %0d want %0d", InstrCount, EXP_COUNT);
        end
        Run = 1'b1; OpCode = 6'h02;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (obs !== M_HALT) begin n_err++; $display("FAIL halt_stuck%0d got %h want %h", k, obs, M_HALT); end
        end
        Run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_reset_mid_lw();
        test_in();
        test_run_gate();
        test_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
